// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state and grant encodings for the memory bus arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
    typedef enum logic {GNT_I, GNT_D} grant_t;
endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: saturating busy-cycle counter that flags an unanswered bus access
module bus_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = TIMEOUT > 0 ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt;

    // count unanswered busy cycles, holding at the expiry value instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (tick && cnt != LAST)
            cnt <= cnt + 1'b1;
    end

    assign expired = (TIMEOUT > 0) && (cnt == LAST);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin share of one valid/ready memory port between fetch and data
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [XLEN-1:0]   i_addr,
    output logic              i_ready,
    output logic              i_err,
    output logic [XLEN-1:0]   i_rdata,
    input  logic              d_valid,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [XLEN/8-1:0] d_wstrb,
    output logic              d_ready,
    output logic              d_err,
    output logic [XLEN-1:0]   d_rdata,
    output logic              mem_valid,
    output logic              mem_instr,
    input  logic              mem_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic [XLEN-1:0]   mem_rdata
);
    arb_state_t state, state_nxt;
    grant_t     last_grant;
    logic       busy, grant_i, start, wd_exp, done, err;

    assign busy    = state != IDLE;
    assign start   = state == IDLE && (i_valid || d_valid);
    assign grant_i = i_valid && (!d_valid || last_grant == GNT_D);

    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .reset   (reset),
        .clear   (!busy),
        .tick    (busy && !mem_ready),
        .expired (wd_exp)
    );

    // state register; reset drops mem_valid immediately since it is decoded from state
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next state and completion decode; a real answer beats a same-cycle expiry
    always_comb begin
        state_nxt = state;
        done      = busy && (mem_ready || wd_exp);
        err       = busy && !mem_ready && wd_exp;
        if (start)
            state_nxt = grant_i ? BUSY_I : BUSY_D;
        else if (done)
            state_nxt = IDLE;
    end

    // latch the winner's payload on grant; fetches carry no store data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GNT_D;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else if (start) begin
            last_grant <= grant_i ? GNT_I : GNT_D;
            mem_addr   <= grant_i ? i_addr : d_addr;
            mem_wdata  <= grant_i ? '0 : d_wdata;
            mem_wstrb  <= grant_i ? '0 : d_wstrb;
        end
    end

    assign mem_valid = busy;
    assign mem_instr = state == BUSY_I;
    assign i_ready   = state == BUSY_I && done;
    assign i_err     = state == BUSY_I && err;
    assign d_ready   = state == BUSY_D && done;
    assign d_err     = state == BUSY_D && err;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of arbitration, payload, latency, reset and watchdog
module tb_mem_bus_arbiter;
    logic        clk = 0, reset = 1;
    logic        i_valid = 0, d_valid = 0, mem_ready = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic [3:0]  d_wstrb = 0;
    logic        i_ready, i_err, d_ready, d_err, mem_valid, mem_instr;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        i_ready0, i_err0, d_ready0, d_err0, mem_valid0, mem_instr0;
    logic [31:0] i_rdata0, d_rdata0, mem_addr0, mem_wdata0;
    logic [3:0]  mem_wstrb0;
    int          n_checks = 0, n_fail = 0;
    logic        seen0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.XLEN(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_err(i_err), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(d_ready), .d_err(d_err), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    mem_bus_arbiter #(.XLEN(32), .TIMEOUT(0)) dut0 (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready0), .i_err(i_err0), .i_rdata(i_rdata0),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(d_ready0), .d_err(d_err0), .d_rdata(d_rdata0),
        .mem_valid(mem_valid0), .mem_instr(mem_instr0), .mem_ready(mem_ready), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_wstrb(mem_wstrb0), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nx;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (2) nx;
        #1;
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_instr", mem_instr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wstrb", mem_wstrb, 0);
        check("rst_readys", {i_ready, d_ready, i_err, d_err}, 0);
        reset = 0;
        nx; d_valid = 1; d_addr = 32'h40;
        nx; #1;
        check("rstmid_busy_d", {mem_valid, mem_instr}, 2'b10);
        reset = 1; #1;
        check("rstmid_valid_drop", mem_valid, 0);
        check("rstmid_no_dready", d_ready, 0);
        i_valid = 1; i_addr = 32'h44;
        nx;
        check("rstmid_no_dready2", d_ready, 0);
        reset = 0;
        nx; #1;
        check("rst_first_tie_fetch", {mem_valid, mem_instr}, 2'b11);
        check("rst_first_tie_addr", mem_addr, 32'h44);
        mem_ready = 1; mem_rdata = 32'h11; #1;
        check("rst_fetch_done", {i_ready, d_ready}, 2'b10);
        i_valid = 0; d_valid = 0;
        nx; mem_ready = 0; #1;
        check("rst_back_idle", mem_valid, 0);

        // store
        d_valid = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
        nx; #1;
        check("st_valid_instr", {mem_valid, mem_instr}, 2'b10);
        check("st_addr", mem_addr, 32'h2000);
        check("st_wdata", mem_wdata, 32'hDEADBEEF);
        check("st_wstrb", mem_wstrb, 4'b0011);
        check("st_no_ready", d_ready, 0);
        nx; #1;
        check("st_addr_hold", mem_addr, 32'h2000);
        check("st_wdata_hold", mem_wdata, 32'hDEADBEEF);
        mem_ready = 1; mem_rdata = 32'h55; #1;
        check("st_done", {d_ready, d_err, i_ready}, 3'b100);
        d_valid = 0;
        nx; mem_ready = 0; #1;
        check("st_idle", {mem_valid, d_ready}, 0);

        // tie with immediate answers: I,D,I,D with one bubble each
        i_valid = 1; d_valid = 1; i_addr = 32'h200; d_addr = 32'h300; d_wstrb = 4'hF; mem_ready = 1;
        for (int k = 0; k < 4; k++) begin
            nx; #1;
            check("tie_grant", {mem_valid, mem_instr}, (k % 2 == 0) ? 2'b11 : 2'b10);
            check("tie_addr", mem_addr, (k % 2 == 0) ? 32'h200 : 32'h300);
            check("tie_ready", {i_ready, d_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
            nx; #1;
            check("tie_bubble", mem_valid, 0);
        end
        i_valid = 0; d_valid = 0; mem_ready = 0;

        // single fetch with two-cycle memory latency; store payload must not leak
        nx; i_valid = 1; i_addr = 32'h100; d_wdata = 32'hFFFFFFFF; d_wstrb = 4'hF;
        nx; #1;
        check("f_valid_instr", {mem_valid, mem_instr}, 2'b11);
        check("f_addr", mem_addr, 32'h100);
        check("f_wstrb", mem_wstrb, 0);
        check("f_wdata", mem_wdata, 0);
        check("f_wait1", i_ready, 0);
        nx; #1;
        check("f_wait2", i_ready, 0);
        nx; mem_ready = 1; mem_rdata = 32'h00000013; #1;
        check("f_ready", {i_ready, i_err, d_ready}, 3'b100);
        check("f_rdata", i_rdata, 32'h13);
        i_valid = 0;
        nx; mem_ready = 0; #1;
        check("f_idle", {mem_valid, i_ready}, 0);

        // answer on the expiry cycle wins
        d_valid = 1; d_addr = 32'h84; d_wstrb = 0;
        for (int k = 1; k < 8; k++) begin
            nx; #1;
            check("bnd_wait", d_ready, 0);
        end
        nx; mem_ready = 1; mem_rdata = 32'hCAFE; #1;
        check("bnd_ready_noerr", {d_ready, d_err}, 2'b10);
        check("bnd_rdata", d_rdata, 32'hCAFE);
        d_valid = 0;
        nx; mem_ready = 0; #1;
        check("bnd_idle", mem_valid, 0);

        // timeout with TIMEOUT=8 and no watchdog with TIMEOUT=0
        d_valid = 1; d_addr = 32'h88;
        seen0 = 0;
        for (int k = 1; k < 8; k++) begin
            nx; #1;
            check("to_wait", {mem_valid, d_ready}, 2'b10);
        end
        nx; #1;
        check("to_expire", {d_ready, d_err, mem_valid}, 3'b111);
        check("to0_no_expire", {d_ready0, d_err0}, 0);
        d_valid = 0;
        nx; #1;
        check("to_valid_drop", {mem_valid, d_ready}, 0);
        for (int k = 0; k < 20; k++) begin
            nx; #1;
            seen0 = seen0 | d_ready0 | d_err0 | !mem_valid0;
        end
        check("to0_stays_busy", {mem_valid0, seen0}, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
